// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw pin in, cleaned level/strobes/count out.
interface button_debouncer_if;
    logic       pmod;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [3:0] led;

    // Driver of the raw pin and consumer of button events
    modport master (
        output pmod,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  led
    );

    // Debouncer side
    modport slave (
        input  pmod,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output led
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, stability counter and a
// four-state FSM producing a clean level, press/release strobes and a
// wrapping 4-bit press count.
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 600000,
    parameter int unsigned ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                rst,
    button_debouncer_if.slave   bus
);

    localparam int unsigned   CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic          REL_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [3:0]       led_q, led_d;
    logic             sync_press_c;

    // Normalize the synchronized pin so 1 always means pressed
    assign sync_press_c = sync2_q ^ REL_PIN;

    // Synchronizer, state register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= REL_PIN;
            sync2_q   <= REL_PIN;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            led_q     <= 4'h0;
        end else begin
            sync1_q   <= bus.pmod;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            led_q     <= led_d;
        end
    end

    // Next-state, counter and output logic; counter clears whenever the
    // synchronized input agrees with the debounced level
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        led_d     = led_q;
        unique case (state_q)
            RELEASED: begin
                if (sync_press_c) begin
                    state_d = PRESS_PENDING;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_PENDING: begin
                if (!sync_press_c) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    led_d   = led_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_press_c) begin
                    state_d = RELEASE_PENDING;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_PENDING: begin
                if (sync_press_c) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.led           = led_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, ACTIVE_LOW=1.
module tb_button_debouncer;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   npress;

    button_debouncer_if bus ();

    button_debouncer #(
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.pmod = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drive pmod to a new value and check the strobe lands on the 6th edge
    task automatic press_release(input logic [3:0] exp_led);
        bus.pmod = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pr_pre_press", 8'(bus.press_pulse), 8'd0);
        tick();
        chk("pr_press", 8'(bus.press_pulse), 8'd1);
        chk("pr_led", 8'(bus.led), 8'(exp_led));
        bus.pmod = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("pr_release", 8'(bus.release_pulse), 8'd1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        npress   = 0;
        rst      = 1'b1;
        bus.pmod = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_level", 8'(bus.btn_level), 8'd0);
        chk("rst_press", 8'(bus.press_pulse), 8'd0);
        chk("rst_release", 8'(bus.release_pulse), 8'd0);
        chk("rst_led", 8'(bus.led), 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_level", 8'(bus.btn_level), 8'd0);
            chk("idle_press", 8'(bus.press_pulse), 8'd0);
        end
        chk("idle_led", 8'(bus.led), 8'd0);

        // Clean press: pulse at edge k+5
        bus.pmod = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("clean_wait_level", 8'(bus.btn_level), 8'd0);
            chk("clean_wait_press", 8'(bus.press_pulse), 8'd0);
        end
        tick();
        chk("clean_level", 8'(bus.btn_level), 8'd1);
        chk("clean_press", 8'(bus.press_pulse), 8'd1);
        chk("clean_led", 8'(bus.led), 8'd1);
        tick();
        chk("clean_press_one_cycle", 8'(bus.press_pulse), 8'd0);
        chk("clean_level_hold", 8'(bus.btn_level), 8'd1);

        // Bounce: 0,1,0,1 two cycles each, then settle to 0
        do_reset();
        for (int p = 0; p < 4; p++) begin
            bus.pmod = (p % 2 == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 2; i++) begin
                tick();
                if (bus.press_pulse) npress++;
            end
        end
        bus.pmod = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.press_pulse) npress++;
        end
        chk("bounce_no_early_press", 8'(npress), 8'd0);
        tick();
        chk("bounce_press", 8'(bus.press_pulse), 8'd1);
        for (int i = 0; i < 5; i++) begin
            if (bus.press_pulse) npress++;
            tick();
        end
        chk("bounce_one_pulse", 8'(npress), 8'd1);
        chk("bounce_led", 8'(bus.led), 8'd1);

        // Release glitch of 3 cycles is filtered
        bus.pmod = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.pmod = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_no_release", 8'(bus.release_pulse), 8'd0);
            chk("glitch_level", 8'(bus.btn_level), 8'd1);
        end
        bus.pmod = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rel_wait", 8'(bus.release_pulse), 8'd0);
        end
        tick();
        chk("rel_pulse", 8'(bus.release_pulse), 8'd1);
        chk("rel_level", 8'(bus.btn_level), 8'd0);
        chk("rel_no_press", 8'(bus.press_pulse), 8'd0);
        tick();
        chk("rel_one_cycle", 8'(bus.release_pulse), 8'd0);

        // Wrap: 17 press/release pairs, led = n mod 16
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            press_release(4'(n));
        end
        chk("wrap_final_led", 8'(bus.led), 8'd1);

        // Reset two cycles into PRESS_PENDING
        do_reset();
        bus.pmod = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midrst_press", 8'(bus.press_pulse), 8'd0);
            chk("midrst_level", 8'(bus.btn_level), 8'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_wait", 8'(bus.press_pulse), 8'd0);
        end
        tick();
        chk("midrst_press_after", 8'(bus.press_pulse), 8'd1);
        chk("midrst_led", 8'(bus.led), 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
